// File: rtl/i2c_slave_byte_ctl.sv
// I2C target byte controller: synchronizes and filters SCL/SDA, detects
// START/STOP, matches a 7-bit address and moves bytes in both directions
// with one-cycle strobes toward the user side.
// Optional feature macro: I2C_SLV_STRETCH_EN (hold SCL low while a read
// byte is still missing instead of sending 8'hFF).
module i2c_slave_byte_ctl #(
  parameter logic [6:0]  P_SLV_ADDR = 7'h50,
  parameter int unsigned P_FILT     = 4
) (
  input  logic       i_sysclk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_ack_en,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda,
  output logic       o_sda_oen,
  output logic       o_scl,
  output logic       o_scl_oen,
  output logic       o_start,
  output logic       o_rw,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_req,
  output logic       o_tx_underrun,
  output logic       o_nack,
  output logic       o_stop,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
  } state_e;

  localparam logic [3:0] FILT_LAST = 4'(P_FILT - 1);

  // Front end: synchronizers, glitch filters, previous filtered levels
  logic       scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_fp_q, sda_fp_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Protocol state
  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
  logic       rw_q, rw_d, busy_q, busy_d, sda_oen_q, sda_oen_d;
  logic       tx_have_q, tx_have_d;
  logic       start_q, start_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       underrun_q, underrun_d, nack_q, nack_d, stop_q, stop_d;
  logic       load_now, tx_avail;
  logic [7:0] tx_byte;
`ifdef I2C_SLV_STRETCH_EN
  logic       stretch_q, stretch_d, scl_oen_q;
`endif

  // A filtered level flips only after P_FILT consecutive differing samples
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned (no latches).
    scl_f_d   = scl_f_q;
    sda_f_d   = sda_f_q;
    scl_cnt_d = 4'd0;
    sda_cnt_d = 4'd0;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == FILT_LAST) scl_f_d = scl_s2_q;
      else                        scl_cnt_d = scl_cnt_q + 4'd1;
    end
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == FILT_LAST) sda_f_d = sda_s2_q;
      else                        sda_cnt_d = sda_cnt_q + 4'd1;
    end
  end

  // Front-end registers; idle bus level is high
  always_ff @(posedge i_sysclk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; sda_s1_q <= 1'b1; sda_s2_q <= 1'b1;
      scl_f_q  <= 1'b1; sda_f_q  <= 1'b1; scl_fp_q <= 1'b1; sda_fp_q <= 1'b1;
      scl_cnt_q <= 4'd0; sda_cnt_q <= 4'd0;
    end else begin
      scl_s1_q <= i_scl;   scl_s2_q <= scl_s1_q;
      sda_s1_q <= i_sda;   sda_s2_q <= sda_s1_q;
      scl_f_q  <= scl_f_d; sda_f_q  <= sda_f_d;
      scl_fp_q <= scl_f_q; sda_fp_q <= sda_f_q;
      scl_cnt_q <= scl_cnt_d; sda_cnt_q <= sda_cnt_d;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_fp_q;
  assign scl_fall  = ~scl_f_q & scl_fp_q;
  assign start_det = scl_f_q & scl_fp_q & sda_fp_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_fp_q & ~sda_fp_q & sda_f_q;

  assign tx_avail = tx_have_q | i_tx_valid;
  assign tx_byte  = tx_have_q ? tx_buf_q : i_tx_data;

  // Next-state and strobe logic; STOP outranks START, disable outranks both
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_oen_d  = sda_oen_q;
    tx_buf_d   = tx_buf_q;
    tx_have_d  = tx_have_q;
    start_d    = 1'b0;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    underrun_d = 1'b0;
    nack_d     = 1'b0;
    stop_d     = 1'b0;
    load_now   = 1'b0;
`ifdef I2C_SLV_STRETCH_EN
    stretch_d  = stretch_q;
`endif
    if (i_tx_valid && !tx_have_q) begin
      tx_buf_d  = i_tx_data;
      tx_have_d = 1'b1;
    end

    if (!i_enable || stop_det || start_det) begin
      state_d   = (i_enable && !stop_det) ? ADDR : IDLE;
      stop_d    = i_enable && stop_det && busy_q;
      busy_d    = (i_enable && !stop_det) ? busy_q : 1'b0;
      bit_cnt_d = 4'd0;
      sda_oen_d = 1'b1;
      tx_have_d = 1'b0;
`ifdef I2C_SLV_STRETCH_EN
      stretch_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (shift_q[6:0] == P_SLV_ADDR) begin
                start_d = 1'b1;
                rw_d    = sda_f_q;
                busy_d  = 1'b1;
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d   = ADDR_ACK;
            sda_oen_d = 1'b0;
            tx_req_d  = rw_q;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              load_now = 1'b1;
            end else begin
              state_d   = RX_DATA;
              sda_oen_d = 1'b1;
              bit_cnt_d = 4'd0;
            end
          end
        end
        RX_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = {shift_q[6:0], sda_f_q};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d   = i_ack_en ? RX_ACK : WAIT_STOP;
            sda_oen_d = ~i_ack_en;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            state_d   = RX_DATA;
            sda_oen_d = 1'b1;
            bit_cnt_d = 4'd0;
          end
        end
        TX_DATA: begin
`ifdef I2C_SLV_STRETCH_EN
          if (stretch_q) load_now = 1'b1; else
`endif
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = TX_ACK;
              sda_oen_d = 1'b1;
              bit_cnt_d = 4'd0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b1};
              sda_oen_d = shift_q[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_f_q) begin
              tx_req_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              nack_d  = 1'b1;
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            load_now = 1'b1;
          end
        end
        WAIT_STOP: sda_oen_d = 1'b1;
        default:   sda_oen_d = 1'b1;
      endcase
    end

    // Fetch the next read byte and put its MSB on the bus
    if (load_now) begin
`ifdef I2C_SLV_STRETCH_EN
      if (tx_avail) begin
        shift_d   = tx_byte;
        sda_oen_d = tx_byte[7];
        tx_have_d = 1'b0;
        stretch_d = 1'b0;
      end else begin
        sda_oen_d = 1'b1;
        stretch_d = 1'b1;
      end
`else
      shift_d    = tx_avail ? tx_byte : 8'hFF;
      sda_oen_d  = shift_d[7];
      underrun_d = ~tx_avail;
      tx_have_d  = 1'b0;
`endif
      state_d   = TX_DATA;
      bit_cnt_d = 4'd0;
    end
  end

  // Protocol registers; reset releases the bus and drops any partial byte
  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      state_q   <= IDLE;       bit_cnt_q <= 4'd0;       shift_q   <= 8'h00;
      rx_data_q <= 8'h00;      tx_buf_q  <= 8'h00;      tx_have_q <= 1'b0;
      rw_q      <= 1'b0;       busy_q    <= 1'b0;       sda_oen_q <= 1'b1;
      start_q   <= 1'b0;       rx_valid_q <= 1'b0;      tx_req_q  <= 1'b0;
      underrun_q <= 1'b0;      nack_q    <= 1'b0;       stop_q    <= 1'b0;
`ifdef I2C_SLV_STRETCH_EN
      stretch_q <= 1'b0;       scl_oen_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;    bit_cnt_q <= bit_cnt_d;  shift_q   <= shift_d;
      rx_data_q <= rx_data_d;  tx_buf_q  <= tx_buf_d;   tx_have_q <= tx_have_d;
      rw_q      <= rw_d;       busy_q    <= busy_d;     sda_oen_q <= sda_oen_d;
      start_q   <= start_d;    rx_valid_q <= rx_valid_d; tx_req_q <= tx_req_d;
      underrun_q <= underrun_d; nack_q   <= nack_d;     stop_q    <= stop_d;
`ifdef I2C_SLV_STRETCH_EN
      // SCL follows the stretch flag a cycle late so SDA settles before release
      stretch_q <= stretch_d;  scl_oen_q <= ~stretch_q;
`endif
    end
  end

  assign o_sda         = 1'b0;
  assign o_scl         = 1'b0;
  assign o_sda_oen     = sda_oen_q;
`ifdef I2C_SLV_STRETCH_EN
  assign o_scl_oen     = scl_oen_q;
`else
  assign o_scl_oen     = 1'b1;
`endif
  assign o_start       = start_q;
  assign o_rw          = rw_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_tx_req      = tx_req_q;
  assign o_tx_underrun = underrun_q;
  assign o_nack        = nack_q;
  assign o_stop        = stop_q;
  assign o_busy        = busy_q;

endmodule
